// File: rtl/tone_voice_scheduler_if.sv
// ============================================================================
//  Module      : tone_voice_scheduler_if
//  Description : Voice configuration write channel (valid/ready + payload).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tone_voice_scheduler_if #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_W     = 16
) ();
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [$clog2(NUM_VOICES)-1:0] cfg_voice;
    logic [FREQ_W-1:0]             cfg_freq;
    logic                          cfg_gate;

    modport master (
        output cfg_valid, cfg_voice, cfg_freq, cfg_gate,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_voice, cfg_freq, cfg_gate,
        output cfg_ready
    );
endinterface

`default_nettype wire

// File: rtl/tone_voice_scheduler.sv
// ============================================================================
//  Module      : tone_voice_scheduler
//  Description : Round-robin tone voices sharing one phase adder; per-frame mix.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 24,
    parameter int FREQ_W     = 16,
    parameter int OUT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 run,
    tone_voice_scheduler_if.slave                cfg,
    output logic [$clog2(NUM_VOICES)-1:0]        slot,
    output logic                                 sample_tick,
    output logic [OUT_W+$clog2(NUM_VOICES)-1:0]  mix_out
);

    localparam int                   c_slot_w = $clog2(NUM_VOICES);
    localparam int                   c_mix_w  = OUT_W + c_slot_w;
    localparam logic [c_slot_w-1:0]  c_slot_one  = c_slot_w'(1);
    localparam logic [c_slot_w-1:0]  c_slot_last = c_slot_w'(NUM_VOICES - 1);

    logic [ACC_W-1:0]    acc_q  [NUM_VOICES];
    logic [ACC_W-1:0]    acc_d  [NUM_VOICES];
    logic [FREQ_W-1:0]   freq_q [NUM_VOICES];
    logic [FREQ_W-1:0]   freq_d [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [c_slot_w-1:0] slot_q, slot_d;
    logic [c_mix_w-1:0]  partial_q, partial_d;
    logic [c_mix_w-1:0]  mix_q, mix_d;
    logic                tick_q, tick_d;

    logic [ACC_W-1:0]    w_new_acc;
    logic [c_mix_w-1:0]  w_contrib;

    // Shared adder: the voice in the current slot, using pre-write freq/gate.
    always_comb begin
        w_new_acc = acc_q[slot_q] + {freq_q[slot_q], {(ACC_W-FREQ_W){1'b0}}};
        w_contrib = gate_q[slot_q] ? {{c_slot_w{1'b0}}, w_new_acc[ACC_W-1 -: OUT_W]}
                                   : '0;
    end

    always_comb begin
        acc_d     = acc_q;
        freq_d    = freq_q;
        gate_d    = gate_q;
        slot_d    = slot_q;
        partial_d = partial_q;
        mix_d     = mix_q;
        tick_d    = 1'b0;

        if (run) begin
            slot_d = slot_q + c_slot_one;
            if (gate_q[slot_q]) begin
                acc_d[slot_q] = w_new_acc;
            end
            if (slot_q == c_slot_last) begin
                mix_d     = partial_q + w_contrib;
                partial_d = '0;
                tick_d    = 1'b1;
            end else begin
                partial_d = partial_q + w_contrib;
            end
        end else begin
            slot_d    = '0;
            partial_d = '0;
        end

        // Applied last so a gate-on phase reset wins over the slot update.
        if (cfg.cfg_valid) begin
            freq_d[cfg.cfg_voice] = cfg.cfg_freq;
            gate_d[cfg.cfg_voice] = cfg.cfg_gate;
            if (cfg.cfg_gate && !gate_q[cfg.cfg_voice]) begin
                acc_d[cfg.cfg_voice] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                acc_q[i]  <= '0;
                freq_q[i] <= '0;
            end
            gate_q    <= '0;
            slot_q    <= '0;
            partial_q <= '0;
            mix_q     <= '0;
            tick_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            freq_q    <= freq_d;
            gate_q    <= gate_d;
            slot_q    <= slot_d;
            partial_q <= partial_d;
            mix_q     <= mix_d;
            tick_q    <= tick_d;
        end
    end

    assign cfg.cfg_ready = 1'b1;
    assign slot          = slot_q;
    assign sample_tick   = tick_q;
    assign mix_out       = mix_q;

endmodule

`default_nettype wire

// File: tb/tb_tone_voice_scheduler.sv
// ============================================================================
//  Module      : tb_tone_voice_scheduler
//  Description : Directed self-checking bench for tone_voice_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tone_voice_scheduler;

    logic       clk;
    logic       reset;
    logic       run;
    logic [1:0] slot;
    logic       sample_tick;
    logic [9:0] mix_out;

    int total;
    int bad;

    tone_voice_scheduler_if #(.NUM_VOICES(4), .FREQ_W(16)) cfg_if ();

    tone_voice_scheduler #(
        .NUM_VOICES (4),
        .ACC_W      (24),
        .FREQ_W     (16),
        .OUT_W      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .cfg         (cfg_if.slave),
        .slot        (slot),
        .sample_tick (sample_tick),
        .mix_out     (mix_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        run              = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [15:0] f, input logic g);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_voice = v;
        cfg_if.cfg_freq  = f;
        cfg_if.cfg_gate  = g;
        step(1);
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Advances until sample_tick is seen; returns the number of edges taken.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        while (cycles < 64) begin
            step(1);
            cycles++;
            if (sample_tick) break;
        end
        if (!sample_tick) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_slot(input logic [1:0] s);
        int n;
        n = 0;
        while (slot != s && n < 16) begin
            step(1);
            n++;
        end
        check("wait_slot", {30'd0, slot}, {30'd0, s});
    endtask

    initial begin
        int c;
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        run              = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_voice = 2'd0;
        cfg_if.cfg_freq  = 16'd0;
        cfg_if.cfg_gate  = 1'b0;

        // T1: reset state, then one slow voice across 256 frames
        step(3);
        reset = 1'b0;
        check("rst_slot", {30'd0, slot}, 32'd0);
        check("rst_mix", {22'd0, mix_out}, 32'd0);
        check("rst_tick", {31'd0, sample_tick}, 32'd0);
        check("rst_acc0", {8'd0, dut.acc_q[0]}, 32'd0);
        check("cfg_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        cfg_write(2'd0, 16'h0001, 1'b1);
        check("t1_acc0_init", {8'd0, dut.acc_q[0]}, 32'd0);
        run = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            wait_tick(c);
            check("t1_gap", c, 32'd4);
            check("t1_mix", {22'd0, mix_out}, (k >> 8) & 32'hff);
        end
        check("t1_acc0_final", {8'd0, dut.acc_q[0]}, 32'h010000);

        // T2: four half-rate voices alternate 0x200 / 0x000
        do_reset();
        for (int v = 0; v < 4; v++) cfg_write(v[1:0], 16'h8000, 1'b1);
        run = 1'b1;
        wait_tick(c);
        check("t2_gap1", c, 32'd4);
        check("t2_mix1", {22'd0, mix_out}, 32'h200);
        wait_tick(c);
        check("t2_mix2", {22'd0, mix_out}, 32'h000);
        wait_tick(c);
        check("t2_mix3", {22'd0, mix_out}, 32'h200);

        // T3: voice 1 gated off
        do_reset();
        for (int v = 0; v < 4; v++) cfg_write(v[1:0], 16'h8000, (v != 1));
        run = 1'b1;
        wait_tick(c);
        check("t3_mix1", {22'd0, mix_out}, 32'h180);
        check("t3_acc1_a", {8'd0, dut.acc_q[1]}, 32'd0);
        wait_tick(c);
        check("t3_mix2", {22'd0, mix_out}, 32'h000);
        check("t3_acc1_b", {8'd0, dut.acc_q[1]}, 32'd0);

        // T4: gate-on write colliding with its own slot
        do_reset();
        run = 1'b1;
        wait_slot(2'd2);
        cfg_write(2'd2, 16'h4000, 1'b1);
        check("t4_slot", {30'd0, slot}, 32'd3);
        check("t4_acc2_clr", {8'd0, dut.acc_q[2]}, 32'd0);
        wait_tick(c);
        check("t4_gap", c, 32'd1);
        check("t4_mix_old", {22'd0, mix_out}, 32'h000);
        step(3);
        check("t4_slot3", {30'd0, slot}, 32'd3);
        check("t4_acc2_run", {8'd0, dut.acc_q[2]}, 32'h400000);
        wait_tick(c);
        check("t4_mix_new", {22'd0, mix_out}, 32'h040);

        // T5: halt mid-frame, then resume
        wait_slot(2'd2);
        run = 1'b0;
        step(1);
        check("t5_slot0", {30'd0, slot}, 32'd0);
        check("t5_notick", {31'd0, sample_tick}, 32'd0);
        check("t5_mix_hold", {22'd0, mix_out}, 32'h040);
        check("t5_acc2_hold", {8'd0, dut.acc_q[2]}, 32'h400000);
        step(3);
        check("t5_notick2", {31'd0, sample_tick}, 32'd0);
        check("t5_slot_hold", {30'd0, slot}, 32'd0);
        run = 1'b1;
        wait_tick(c);
        check("t5_gap", c, 32'd4);
        check("t5_mix", {22'd0, mix_out}, 32'h080);

        // T6: reset mid-frame
        wait_slot(2'd2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t6_slot", {30'd0, slot}, 32'd0);
        check("t6_mix", {22'd0, mix_out}, 32'd0);
        check("t6_tick", {31'd0, sample_tick}, 32'd0);
        check("t6_acc2", {8'd0, dut.acc_q[2]}, 32'd0);
        check("t6_partial", {22'd0, dut.partial_q}, 32'd0);
        wait_tick(c);
        check("t6_gap", c, 32'd4);
        check("t6_mix_after", {22'd0, mix_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
